// File: rtl/grf_pkg.sv
// Shared GRF definitions: register count, index width, zero register and the
// dump engine state encoding.
package grf_pkg;
    localparam int NREG_DEFAULT = 32;
    localparam int REG_AW       = 5;
    localparam int ZERO_REG     = 0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } state_t;
endpackage

// File: rtl/grf_bypass_mux.sv
// GRF read with write-back bypass: r0 reads zero, a same-cycle write to the
// read address wins over the stale array data.
module grf_bypass_mux
    import grf_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = 32
) (
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_rd_data,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [DW-1:0] i_wb_data,
    output logic [DW-1:0] o_value
);
    always_comb begin
        if (i_addr == AW'(ZERO_REG))
            o_value = '0;
        else if (i_wb_we && (i_wb_addr == i_addr))
            o_value = i_wb_data;
        else
            o_value = i_rd_data;
    end
endmodule

// File: rtl/grf_dump.sv
// Debug readout engine: walks every GRF register through a spare read port and
// streams {index, value} beats over valid/ready, one beat per cycle.
module grf_dump
    import grf_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int DW   = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);
    state_t        r_state;
    logic [AW-1:0] r_idx;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_done;

    logic          w_idx_last;
    logic          w_fire;
    logic [AW-1:0] w_rd_addr;
    logic [DW-1:0] w_cap;

    assign w_idx_last = (r_idx == AW'(NREG - 1));
    assign w_fire     = r_valid && out_ready;

    // Look one register ahead so the next beat's value is ready at the fire edge.
    always_comb begin
        w_rd_addr = '0;
        if (r_state == STREAM)
            w_rd_addr = w_idx_last ? r_idx : r_idx + 1'b1;
    end

    grf_bypass_mux #(.AW(AW), .DW(DW)) u_bypass (
        .i_addr    (w_rd_addr),
        .i_rd_data (rd_data),
        .i_wb_we   (wb_we),
        .i_wb_addr (wb_addr),
        .i_wb_data (wb_data),
        .o_value   (w_cap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start)
                        r_state <= LOAD;
                end
                LOAD: begin
                    // Register 0 is hardwired to zero, so beat 0 needs no read.
                    r_idx   <= '0;
                    r_data  <= '0;
                    r_valid <= 1'b1;
                    r_state <= STREAM;
                end
                STREAM: begin
                    if (w_fire) begin
                        if (w_idx_last) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                            r_data <= w_cap;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_addr   = w_rd_addr;
    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign out_data  = r_data;
    assign out_last  = r_valid && w_idx_last;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
endmodule

// File: tb/tb_grf_dump.sv
// Randomized bench for grf_dump: a GRF array model plus a beat scoreboard that
// predicts each beat's value from the capture rules at the cycle it is read.
module tb_grf_dump;
    localparam int NREG = 32;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          wb_we = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_addr;
    logic          out_valid, out_last, busy, done;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;

    logic [DW-1:0] grf [NREG];

    always #5 clk = ~clk;
    always_comb rd_data = grf[rd_addr];

    grf_dump #(.NREG(NREG), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard state
    logic [DW-1:0] exp_val [NREG];
    int            exp_idx = 0;
    int            beats = 0;
    int            dones = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            done_lat = 0;
    bit            m_idle = 1'b1;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_idx;
    logic [DW-1:0] prev_data;

    task automatic rand_wb();
        wb_we   = 1'($urandom_range(0, 1));
        wb_addr = AW'($urandom_range(0, NREG - 1));
        wb_data = $urandom;
    endtask

    task automatic preload();
        for (int i = 0; i < NREG; i++) grf[i] = DW'(32'h1000 + i);
        grf[0] = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_idx"}, out_idx, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rdaddr"}, rd_addr, 0);
    endtask

    // One clock: inputs already driven by caller at the preceding negedge.
    task automatic tick();
        bit            fire, fire_last, we_now;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        int            nx;
        #1;
        if (m_idle) chk("idle_valid", out_valid, 0);
        if (out_valid) begin
            chk("idx", out_idx, exp_idx);
            chk("data", out_data, exp_val[exp_idx]);
            chk("last", out_last, exp_idx == NREG - 1);
            chk("busy_stream", busy, 1);
        end
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_idx", out_idx, prev_idx);
            chk("stall_data", out_data, prev_data);
        end
        fire      = out_valid && out_ready;
        fire_last = fire && (exp_idx == NREG - 1);
        if (fire && exp_idx < NREG - 1) begin
            nx = exp_idx + 1;
            exp_val[nx] = (wb_we && wb_addr == AW'(nx)) ? wb_data : grf[nx];
        end
        if (fire) begin
            beats++;
            exp_idx++;
        end
        prev_stall = out_valid && !out_ready;
        prev_idx   = out_idx;
        prev_data  = out_data;
        if (start && m_idle) begin
            m_idle     = 1'b0;
            start_cyc  = cyc;
            exp_idx    = 0;
            exp_val[0] = '0;
        end
        we_now = wb_we; wa = wb_addr; wd = wb_data;
        @(posedge clk);
        cyc++;
        #1 if (we_now) grf[wa] = wd;
        @(negedge clk);
        chk("done", done, fire_last);
        if (fire_last) begin
            dones++;
            chk("done_busy", busy, 0);
            m_idle   = 1'b1;
            done_lat = cyc - start_cyc;
        end
    endtask

    // mode 0: ready=1, no writes; 1: ready 1,0,0,1; 2: random ready + writes
    task automatic run_dump(input int mode, input bit bypass, input bit busy_start, input bit abort);
        bit start_done = 1'b0;
        bit aborted = 1'b0;
        preload();
        beats = 0;
        dones = 0;
        start = 1'b1;
        out_ready = 1'b1;
        if (mode == 0) wb_we = 1'b0; else rand_wb();
        tick();
        start = 1'b0;
        for (int c = 0; c < 400 && dones == 0; c++) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (c % 4 == 0) || (c % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 0) wb_we = 1'b0; else rand_wb();
            if (bypass && c == 0) begin
                wb_we = 1'b1; wb_addr = '0; wb_data = 32'hDEADBEEF;
            end
            if (bypass && out_valid && out_ready && out_idx == 4) begin
                wb_we = 1'b1; wb_addr = 5; wb_data = 32'hDEADBEEF;
            end
            if (bypass && out_valid && out_idx == 5 && prev_idx != 5)
                chk("bypass5", out_data, 32'hDEADBEEF);
            if (bypass && out_valid && out_idx == 0 && c == 1)
                chk("bypass0", out_data, 0);
            if (mode == 0 && out_valid)
                chk("const", out_data, (out_idx == 0) ? 0 : 32'h1000 + out_idx);
            if (busy_start && !start_done && out_valid && out_idx == 10) begin
                start = 1'b1;
                start_done = 1'b1;
            end
            if (abort && out_valid && out_idx == 17) begin
                #2 reset = 1'b0;
                #1 check_reset_outputs("abort");
                @(negedge clk);
                @(negedge clk);
                check_reset_outputs("abort_hold");
                reset = 1'b1;
                m_idle = 1'b1;
                prev_stall = 1'b0;
                aborted = 1'b1;
                break;
            end
            tick();
            start = 1'b0;
        end
        start = 1'b0;
        if (aborted) begin
            chk("abort_dones", dones, 0);
        end else begin
            chk("dones", dones, 1);
            chk("beats", beats, NREG);
            if (mode == 0) chk("latency", done_lat, NREG + 2);
        end
        wb_we = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("no_extra_done", dones, aborted ? 0 : 1);
    endtask

    initial begin
        preload();
        // reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            rand_wb();
            @(negedge clk);
            check_reset_outputs("rst");
        end
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            rand_wb();
            tick();
        end
        chk("no_start_valid", out_valid, 0);

        run_dump(0, 1'b0, 1'b0, 1'b0);   // full dump, ready held high
        run_dump(1, 1'b0, 1'b0, 1'b0);   // backpressure pattern
        run_dump(2, 1'b1, 1'b0, 1'b0);   // bypass on idx 0 and 5, live writes
        run_dump(2, 1'b0, 1'b1, 1'b0);   // start while busy is ignored
        run_dump(2, 1'b0, 1'b0, 1'b1);   // reset mid-stream
        run_dump(0, 1'b0, 1'b0, 1'b0);   // fresh complete dump after abort
        for (int k = 0; k < 3; k++) run_dump(2, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
